// File: rtl/can_pkg.sv
// Shared CAN 2.0A definitions: FSM states, field widths, error codes and the CRC-15 step.
package can_pkg;

  typedef enum logic [3:0] {
    IDLE, ID, CTRL, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF, ERR_WAIT
  } can_state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_STUFF = 2'd1,
    ERR_CRC   = 2'd2,
    ERR_FORM  = 2'd3
  } can_err_e;

  localparam logic [14:0] CRC_POLY = 15'h4599;
  localparam int ID_W   = 11;
  localparam int CTRL_W = 7;
  localparam int CRC_W  = 15;
  localparam int EOF_W  = 7;

  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b,
                                             input logic [14:0] poly);
    logic fb;
    fb = b ^ crc[14];
    return {crc[13:0], 1'b0} ^ (fb ? poly : 15'd0);
  endfunction

endpackage

// File: rtl/rx_block_if.sv
// Received-frame bundle from the CAN receiver to the controller.
interface rx_block_if;
  logic [10:0] address_rx;
  logic [63:0] rx_data;
  logic [3:0]  rx_dlc;
  logic        rx_rtr;
  logic        rx_valid;
  logic        rx_err;
  logic [1:0]  rx_err_code;
  logic        rxing;

  modport master (output address_rx, rx_data, rx_dlc, rx_rtr, rx_valid, rx_err, rx_err_code, rxing);
  modport slave  (input  address_rx, rx_data, rx_dlc, rx_rtr, rx_valid, rx_err, rx_err_code, rxing);
endinterface

// File: rtl/can_crc15.sv
// Serial CRC-15 engine; clr restarts from zero and may coincide with the first enabled bit.
module can_crc15
  import can_pkg::*;
#(
  parameter logic [14:0] POLY = 15'h4599
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [14:0] crc_o
);
  logic [14:0] crc_q, crc_d, base;

  always_comb begin
    base  = clr_i ? 15'd0 : crc_q;
    crc_d = base;
    if (en_i) crc_d = crc15_step(base, bit_i, POLY);
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= '0;
    else if (en_i || clr_i) crc_q <= crc_d;
  end

  assign crc_o = crc_q;
endmodule

// File: rtl/rx_block.sv
// CAN 2.0A standard-frame receiver: destuffing, field parsing, CRC check, ACK drive, error recovery.
module rx_block #(
  parameter int          IDLE_BITS = 11,
  parameter logic [14:0] CRC_POLY  = 15'h4599
) (
  input  logic clk,
  input  logic rst,
  input  logic baud_tick,
  input  logic can_rx,
  output logic can_ack,
  rx_block_if.master rx
);
  import can_pkg::*;

  localparam int IW = $clog2(IDLE_BITS + 1);

  can_state_e  state_q;
  can_err_e    err;
  logic [2:0]  run_q;
  logic        last_q;
  logic [6:0]  cnt_q, len_q, len_d;
  logic [10:0] id_q, addr_q;
  logic [63:0] data_q, data_out_q;
  logic [3:0]  dlc_q, dlc_out_q, dlc_d;
  logic        rtr_q, rtr_out_q;
  logic [14:0] rcrc_q, crc_calc;
  logic [IW-1:0] idle_q;
  logic        valid_q, err_q, ack_q;
  logic [1:0]  code_q;
  logic        stuffed, is_stuff, stuff_err, sof, crc_feed;

  assign stuffed   = state_q inside {ID, CTRL, DATA, CRC};
  assign is_stuff  = stuffed && (run_q == 3'd5);
  assign stuff_err = is_stuff && (can_rx == last_q);
  assign sof       = (state_q == IDLE) && !can_rx;
  assign crc_feed  = sof || (!is_stuff && (state_q inside {ID, CTRL, DATA}));

  can_crc15 #(.POLY(CRC_POLY)) u_crc (
    .clk(clk), .rst(rst), .clr_i(baud_tick && sof), .en_i(baud_tick && crc_feed),
    .bit_i(can_rx), .crc_o(crc_calc)
  );

  // Length decision uses the DLC LSB arriving on the current sample.
  always_comb begin
    dlc_d = {dlc_q[2:0], can_rx};
    if (rtr_q)         len_d = 7'd0;
    else if (dlc_d[3]) len_d = 7'd64;
    else               len_d = {1'b0, dlc_d[2:0], 3'b000};
  end

  // Priority: stuff over CRC over form.
  always_comb begin
    err = ERR_NONE;
    case (state_q)
      ID, DATA, CRC: if (stuff_err) err = ERR_STUFF;
      CTRL:          if (stuff_err) err = ERR_STUFF;
                     else if (!is_stuff && cnt_q == 7'd1 && can_rx) err = ERR_FORM;
      CRC_DEL:       if (crc_calc != rcrc_q) err = ERR_CRC;
                     else if (!can_rx) err = ERR_FORM;
      ACK_DEL, EOF:  if (!can_rx) err = ERR_FORM;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;   run_q <= '0;      last_q <= 1'b1;
      cnt_q <= '0;       len_q <= '0;      id_q <= '0;      data_q <= '0;
      dlc_q <= '0;       rtr_q <= 1'b0;    rcrc_q <= '0;    idle_q <= '0;
      addr_q <= '0;      data_out_q <= '0; dlc_out_q <= '0; rtr_out_q <= 1'b0;
      valid_q <= 1'b0;   err_q <= 1'b0;    ack_q <= 1'b0;   code_q <= '0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (baud_tick) begin
        if (sof) begin
          run_q <= 3'd1; last_q <= 1'b0;
        end else if (stuffed) begin
          run_q  <= (is_stuff || can_rx != last_q) ? 3'd1 : run_q + 3'd1;
          last_q <= can_rx;
        end else begin
          run_q <= '0; last_q <= 1'b1;
        end

        if (err != ERR_NONE) begin
          state_q <= ERR_WAIT; err_q <= 1'b1; code_q <= err; ack_q <= 1'b0; idle_q <= '0;
        end else begin
          case (state_q)
            IDLE: if (!can_rx) begin
              state_q <= ID; cnt_q <= '0; id_q <= '0; data_q <= '0; dlc_q <= '0; rtr_q <= 1'b0;
            end
            ID: if (!is_stuff) begin
              id_q  <= {id_q[9:0], can_rx};
              cnt_q <= (cnt_q == 7'(ID_W - 1)) ? 7'd0 : cnt_q + 7'd1;
              if (cnt_q == 7'(ID_W - 1)) state_q <= CTRL;
            end
            CTRL: if (!is_stuff) begin
              if (cnt_q == 7'd0) rtr_q <= can_rx;
              if (cnt_q >= 7'd3) dlc_q <= dlc_d;
              cnt_q <= (cnt_q == 7'(CTRL_W - 1)) ? 7'd0 : cnt_q + 7'd1;
              if (cnt_q == 7'(CTRL_W - 1)) begin
                len_q   <= len_d;
                state_q <= (len_d == 7'd0) ? CRC : DATA;
              end
            end
            DATA: if (!is_stuff) begin
              data_q[~cnt_q[5:0]] <= can_rx;
              cnt_q <= (cnt_q == len_q - 7'd1) ? 7'd0 : cnt_q + 7'd1;
              if (cnt_q == len_q - 7'd1) state_q <= CRC;
            end
            CRC: if (!is_stuff) begin
              rcrc_q <= {rcrc_q[13:0], can_rx};
              cnt_q  <= (cnt_q == 7'(CRC_W - 1)) ? 7'd0 : cnt_q + 7'd1;
              if (cnt_q == 7'(CRC_W - 1)) state_q <= CRC_DEL;
            end
            CRC_DEL: begin ack_q <= 1'b1; state_q <= ACK;     end
            ACK:     begin ack_q <= 1'b0; state_q <= ACK_DEL; end
            ACK_DEL: begin cnt_q <= '0;   state_q <= EOF;     end
            EOF: begin
              cnt_q <= cnt_q + 7'd1;
              if (cnt_q == 7'(EOF_W - 1)) begin
                addr_q <= id_q; data_out_q <= data_q; dlc_out_q <= dlc_q; rtr_out_q <= rtr_q;
                valid_q <= 1'b1; cnt_q <= '0; state_q <= IDLE;
              end
            end
            ERR_WAIT: begin
              if (!can_rx) idle_q <= '0;
              else if (idle_q == IW'(IDLE_BITS - 1)) begin idle_q <= '0; state_q <= IDLE; end
              else idle_q <= idle_q + 1'b1;
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign can_ack        = ack_q;
  assign rx.address_rx  = addr_q;
  assign rx.rx_data     = data_out_q;
  assign rx.rx_dlc      = dlc_out_q;
  assign rx.rx_rtr      = rtr_out_q;
  assign rx.rx_valid    = valid_q;
  assign rx.rx_err      = err_q;
  assign rx.rx_err_code = code_q;
  assign rx.rxing       = (state_q != IDLE);
endmodule
